uart_trans_fifo: RTL and testbench

Parametrised successor to the line follower's fixed 8N1 UART transmitter. It adds:
- a configurable divisor, data width and stop-bit count;
- a small transmit FIFO, so the controller can queue several bytes (e.g. telemetry bursts) without waiting on `tx_done`;
- optional parity, compiled in or out.

It sits between the command/telemetry logic and the TX pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_trans_fifo.sv | 136 +++++++++++++
 tb/tb_uart_trans_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame-length helper for the FIFO-buffered UART transmitter.
// Parity is compiled in when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } uart_tx_state_t;

  localparam int BAUD_DIV_DEFAULT = 2604;

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Start bit + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int stop_bits,
                                    input int parity_bits);
    return 1 + data_bits + parity_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART shifter; head entry is readable
// combinationally so it can be loaded on the same edge it is popped.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  assign do_push = push & ~full_reg;
  assign do_pop  = pop & ~empty_reg;

  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, do_push};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // Flags are registered from the next pointers; the wrap bit separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                    (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
      empty_reg  <= (wr_ptr_next == rd_ptr_next);
    end
  end

  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/uart_trans_fifo.sv
// FIFO-buffered UART transmitter: start, DATA_BITS LSB first, optional parity
// (UART_TX_PARITY_EN), STOP_BITS stop bits; back-to-back frames with no gap.
module uart_trans_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_odd,
  output logic                 TX,
  output logic                 full,
  output logic                 overflow,
  output logic                 tx_done
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, STOP_BITS, PARITY_BITS);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int BAUD_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  uart_tx_state_t state_reg, state_next;

  logic [BAUD_W-1:0]     baud_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [DATA_BITS-1:0]  fifo_rd_data;
  logic                  fifo_empty;
  logic                  push_accept;
  logic                  baud_tick, frame_end;
  logic                  load, shift;
  logic                  overflow_reg, tx_done_reg;

  assign push_accept = trmt & ~full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (trmt),
    .wr_data (tx_data),
    .pop     (load),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (fifo_empty)
  );

  assign baud_tick = (state_reg == XMIT) && (baud_cnt_reg == BAUD_W'(BAUD_DIV - 1));
  assign frame_end = baud_tick && (bit_cnt_reg == BIT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = XMIT;
      XMIT:    if (frame_end && fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A load both starts a frame from idle and chains the next one at frame end.
  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    case (state_reg)
      IDLE: load = !fifo_empty;
      XMIT: begin
        load  = frame_end && !fifo_empty;
        shift = baud_tick && !load;
      end
      default: ;
    endcase
  end

  always_comb begin
    frame_word                = '1;
    frame_word[0]             = 1'b0;
    frame_word[DATA_BITS:1]   = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
    frame_word[DATA_BITS+1]   = (^fifo_rd_data) ^ parity_odd;
`endif
  end

`ifndef UART_TX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (load) begin
      shift_reg    <= frame_word;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (shift) begin
      shift_reg    <= {1'b1, shift_reg[FRAME_BITS-1:1]};
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= frame_end ? '0 : bit_cnt_reg + BIT_W'(1);
    end else if (state_reg == XMIT) begin
      baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
    end
  end

  assign TX = shift_reg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      tx_done_reg  <= 1'b1;
    end else begin
      overflow_reg <= trmt & full;
      tx_done_reg  <= !push_accept && (state_reg == IDLE) && fifo_empty;
    end
  end

  assign overflow = overflow_reg;
  assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_uart_trans_fifo.sv
// Bench for uart_trans_fifo: a queue-based line model checked every cycle plus
// literal frame checks. Parity cases run when UART_TX_PARITY_EN is defined.
module tb_uart_trans_fifo;

  localparam int BD    = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int DB = 7;
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int FL = 1 + DB + PB + SB;

  logic          clk = 1'b0;
  logic          rst;
  logic          trmt;
  logic [DB-1:0] tx_data;
  logic          parity_odd;
  logic          TX, full, overflow, tx_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_trans_fifo #(
    .BAUD_DIV   (BD),
    .DATA_BITS  (DB),
    .STOP_BITS  (SB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .parity_odd (parity_odd),
    .TX         (TX),
    .full       (full),
    .overflow   (overflow),
    .tx_done    (tx_done)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: expected line level per cycle as a queue, plus a queue of pending bytes.
  bit            line_q[$];
  logic [DB-1:0] fifo_q[$];
  logic          m_full, m_ovf, m_done;
  bit            m_valid = 1'b0;

  function automatic void append_frame(input logic [DB-1:0] d, input logic odd);
    bit b;
    for (int k = 0; k < FL; k++) begin
      if (k == 0) b = 1'b0;
      else if (k <= DB) b = d[k-1];
      else if (PB == 1 && k == DB + 1) b = (^d) ^ odd;
      else b = 1'b1;
      for (int c = 0; c < BD; c++) line_q.push_back(b);
    end
  endfunction

  always @(posedge clk) begin
    bit accept, idle_pre;
    int fsz;
    if (rst === 1'b1) begin
      line_q.delete();
      fifo_q.delete();
      m_full  = 1'b0;
      m_ovf   = 1'b0;
      m_done  = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      accept   = (trmt === 1'b1) && !m_full;
      idle_pre = (line_q.size() == 0);
      fsz      = fifo_q.size();
      m_done   = !accept && idle_pre && (fsz == 0);
      m_ovf    = (trmt === 1'b1) && !accept;
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && fsz > 0) append_frame(fifo_q.pop_front(), parity_odd);
      if (accept) fifo_q.push_back(tx_data);
      m_full = (fifo_q.size() == DEPTH);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("TX", {31'd0, TX}, {31'd0, (line_q.size() > 0) ? line_q[0] : 1'b1});
      check("full", {31'd0, full}, {31'd0, m_full});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("tx_done", {31'd0, tx_done}, {31'd0, m_done});
    end
  end

  int ovf_cnt  = 0;
  int full_cnt = 0;
  int low_cnt  = 0;
  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (full === 1'b1) full_cnt++;
    if (TX === 1'b0) low_cnt++;
  end

  task automatic push(input logic [DB-1:0] d);
    trmt    = 1'b1;
    tx_data = d;
    @(negedge clk);
    trmt    = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (tx_done !== 1'b1 && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Called at the negedge right after the push edge; samples each bit mid-period.
  task automatic check_frame(input string name, input logic [15:0] e, input int nbits);
    check({name, "_idle"}, {31'd0, TX}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      repeat (BD / 2) @(negedge clk);
      check($sformatf("%s_bit%0d", name, i), {31'd0, TX}, {31'd0, e[i]});
      repeat (BD / 2) @(negedge clk);
    end
    check({name, "_done_lo"}, {31'd0, tx_done}, 32'd0);
    @(negedge clk);
    check({name, "_done_hi"}, {31'd0, tx_done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e;
    int cyc, ovf0, full0, low0;

    rst = 1'b1; trmt = 1'b0; tx_data = '0; parity_odd = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_TX", {31'd0, TX}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset released");

`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
    push(7'h07);
    e = 16'b0000_0111_0000_1110;
    check_frame("par_even", e, 11);
    $display("frame 0x07 even parity");
    repeat (3) @(negedge clk);
    parity_odd = 1'b1;
    push(7'h07);
    e = 16'b0000_0110_0000_1110;
    check_frame("par_odd", e, 11);
    $display("frame 0x07 odd parity");
    parity_odd = 1'b0;
`else
    push(8'hA5);
    e = 16'b0000_0011_0100_1010;
    check_frame("a5", e, 10);
    $display("frame 0xA5");
`endif
    repeat (3) @(negedge clk);

    push(DB'(8'h01));
    push(DB'(8'h02));
    push(DB'(8'h03));
    wait_done(4 * FL * BD, cyc);
    check("b2b_len", cyc, 3 * FL * BD);
    $display("three back-to-back frames, %0d cycles to done", cyc);
    repeat (3) @(negedge clk);

    ovf0 = ovf_cnt; full0 = full_cnt;
    for (int i = 0; i < 6; i++) push(DB'(8'h10 + i));
    wait_done(7 * FL * BD, cyc);
    check("ovf_len", cyc, 5 * FL * BD - 3);
    check("ovf_pulses", ovf_cnt - ovf0, 1);
    check("full_seen", {31'd0, (full_cnt - full0) > 0}, 32'd1);
    $display("six pushes into depth-%0d fifo, %0d overflow pulse(s)", DEPTH, ovf_cnt - ovf0);
    repeat (3) @(negedge clk);

    push(DB'(8'h11));
    push(DB'(8'h22));
    push(DB'(8'h33));
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_TX", {31'd0, TX}, 32'd1);
    check("mid_rst_done", {31'd0, tx_done}, 32'd1);
    check("mid_rst_full", {31'd0, full}, 32'd0);
    low0 = low_cnt;
    repeat (3 * FL * BD) @(negedge clk);
    check("mid_rst_quiet", low_cnt - low0, 0);
    check("mid_rst_done_end", {31'd0, tx_done}, 32'd1);
    $display("reset mid-frame, line low cycles afterwards: %0d", low_cnt - low0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
